// File: rtl/am_demod.sv
// Envelope-detecting AM demodulator: full-wave rectifier, integrate-and-dump over
// one carrier period, reciprocal-multiply mean, DC tracker and gained baseband output.
module am_demod #(
    parameter int DECIM      = 120,
    parameter int DC_SHIFT   = 8,
    parameter int GAIN_SHIFT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] am_data,
    input  logic        in_valid,
    output logic [11:0] env_data,
    output logic [11:0] demod_data,
    output logic        out_valid,
    output logic        sat_flag
);

    localparam int     CNT_W  = $clog2(DECIM);
    localparam int     ACC_W  = 12 + CNT_W;
    localparam int     PROD_W = ACC_W + 25;
    localparam int     DC_W   = 12 + DC_SHIFT;
    // round(2^24 / DECIM), computed as (2^25/DECIM + 1) / 2
    localparam longint RECIP  = ((64'sd1 <<< 25) / DECIM + 1) / 2;
    localparam longint HALF   = 64'sd1 <<< 23;

    // ---------------- stage 0: rectify about midscale ----------------
    logic [11:0] rect;
    logic        s0_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours regardless of process order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rect     <= '0;
            s0_valid <= 1'b0;
        end else begin
            s0_valid <= in_valid;
            if (in_valid)
                rect <= (am_data >= 12'd2048) ? am_data - 12'd2048 : 12'd2048 - am_data;
        end
    end

    // ---------------- stage 1: integrate and dump ----------------
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic             s1_dump;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            acc     <= '0;
            sum     <= '0;
            s1_dump <= 1'b0;
        end else begin
            s1_dump <= 1'b0;
            if (s0_valid) begin
                if (cnt == CNT_W'(DECIM - 1)) begin
                    sum     <= acc + ACC_W'(rect);
                    s1_dump <= 1'b1;
                    acc     <= '0;
                    cnt     <= '0;
                end else begin
                    acc <= acc + ACC_W'(rect);
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // ---------------- stages 2-3: mean by reciprocal multiply ----------------
    logic [PROD_W-1:0] prod;
    logic              s2_valid;
    logic [PROD_W-1:0] prod_sh;
    logic [11:0]       s3_env;
    logic              s3_valid;

    assign prod_sh = prod >> 24;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod     <= '0;
            s2_valid <= 1'b0;
            s3_env   <= '0;
            s3_valid <= 1'b0;
        end else begin
            s2_valid <= s1_dump;
            if (s1_dump)
                prod <= PROD_W'(sum) * PROD_W'(RECIP) + PROD_W'(HALF);
            s3_valid <= s2_valid;
            if (s2_valid)
                s3_env <= (prod_sh > PROD_W'(4095)) ? 12'hfff : prod_sh[11:0];
        end
    end

    // ---------------- stage 4: DC removal and gain ----------------
    logic [DC_W-1:0]    dc_acc;
    logic [11:0]        dc;
    logic               seeded;
    logic signed [12:0] diff;
    logic signed [16:0] diff_ext;
    logic signed [16:0] demod_full;
    logic [11:0]        demod_next;
    logic               clip_next;
    logic [DC_W-1:0]    dc_acc_next;

    assign dc         = dc_acc[DC_W-1:DC_SHIFT];
    assign diff       = $signed({1'b0, s3_env}) - $signed({1'b0, dc});
    assign diff_ext   = {{4{diff[12]}}, diff};
    assign demod_full = 17'sd2048 + (diff_ext <<< GAIN_SHIFT);

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        demod_next  = demod_full[11:0];
        clip_next   = 1'b0;
        dc_acc_next = dc_acc - DC_W'(dc) + DC_W'(s3_env);
        if (demod_full < 0) begin
            demod_next = 12'd0;
            clip_next  = 1'b1;
        end else if (demod_full > 17'sd4095) begin
            demod_next = 12'hfff;
            clip_next  = 1'b1;
        end
        // First window after reset only establishes the carrier level.
        if (!seeded) begin
            demod_next  = 12'd2048;
            clip_next   = 1'b0;
            dc_acc_next = DC_W'(s3_env) << DC_SHIFT;
        end
    end

    logic        s4_valid;
    logic [11:0] s4_env;
    logic [11:0] s4_demod;
    logic        s4_clip;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dc_acc   <= '0;
            seeded   <= 1'b0;
            s4_valid <= 1'b0;
            s4_env   <= '0;
            s4_demod <= 12'd2048;
            s4_clip  <= 1'b0;
        end else begin
            s4_valid <= s3_valid;
            if (s3_valid) begin
                s4_env   <= s3_env;
                s4_demod <= demod_next;
                s4_clip  <= clip_next;
                dc_acc   <= dc_acc_next;
                seeded   <= 1'b1;
            end
        end
    end

    // ---------------- output register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            env_data   <= '0;
            demod_data <= 12'd2048;
            out_valid  <= 1'b0;
            sat_flag   <= 1'b0;
        end else begin
            out_valid <= s4_valid;
            if (s4_valid) begin
                env_data   <= s4_env;
                demod_data <= s4_demod;
                if (s4_clip)
                    sat_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_am_demod.sv
// Scoreboard bench for am_demod: directed windows push hand-computed results,
// a monitor pops and compares them (including arrival edge) on every out_valid.
module tb_am_demod;

    localparam int DECIM = 120;
    localparam int LAT   = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] am_data;
    logic        in_valid;
    logic [11:0] env_data;
    logic [11:0] demod_data;
    logic        out_valid;
    logic        sat_flag;

    am_demod #(.DECIM(DECIM), .DC_SHIFT(8), .GAIN_SHIFT(1)) dut (
        .clk        (clk),
        .rst        (rst_n),
        .am_data    (am_data),
        .in_valid   (in_valid),
        .env_data   (env_data),
        .demod_data (demod_data),
        .out_valid  (out_valid),
        .sat_flag   (sat_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int env;
        int demod;
        int sat;
        int edge_no;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected out_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check("env_data", int'(env_data), e.env);
                check("demod_data", int'(demod_data), e.demod);
                check("sat_flag", int'(sat_flag), e.sat);
                check("out_valid edge", cyc, e.edge_no);
            end
        end
    end

    task automatic check_idle(input string tag);
        check({tag, " env_data"}, int'(env_data), 0);
        check({tag, " demod_data"}, int'(demod_data), 2048);
        check({tag, " out_valid"}, int'(out_valid), 0);
        check({tag, " sat_flag"}, int'(sat_flag), 0);
    endtask

    // One full window of DECIM valid samples alternating a0/a1; optional gap
    // cycle after each sample (with junk data) and optional expectation push.
    task automatic run_window(input logic [11:0] a0, input logic [11:0] a1, input bit toggle,
                              input bit expect_out, input int env_e, input int demod_e,
                              input int sat_e);
        for (int i = 0; i < DECIM; i++) begin
            @(negedge clk);
            am_data  = (i % 2 != 0) ? a1 : a0;
            in_valid = 1'b1;
            if (i == DECIM - 1 && expect_out)
                sb.push_back('{env_e, demod_e, sat_e, cyc + 1 + LAT});
            if (toggle) begin
                @(negedge clk);
                in_valid = 1'b0;
                am_data  = 12'd0;
            end
        end
    endtask

    task automatic drain();
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("drain timeout, pending outputs", sb.size(), 0);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        check_idle(tag);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        am_data  = 12'd0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;

        // Idle: nothing may change while in_valid stays low.
        repeat (150) @(negedge clk);
        check_idle("idle mid");
        repeat (150) @(negedge clk);
        check_idle("idle end");

        // Exact midscale: rect 0, seeds to 2048.
        run_window(12'd2048, 12'd2048, 1'b0, 1'b1, 0, 2048, 0);
        drain();

        // Rect 1000 continuous: period DECIM, then gapped input: period 2*DECIM.
        do_reset("reset before rect1000");
        run_window(12'd3048, 12'd1048, 1'b0, 1'b1, 1000, 2048, 0);
        run_window(12'd3048, 12'd1048, 1'b0, 1'b1, 1000, 2048, 0);
        run_window(12'd3048, 12'd1048, 1'b0, 1'b1, 1000, 2048, 0);
        run_window(12'd3048, 12'd1048, 1'b1, 1'b1, 1000, 2048, 0);
        run_window(12'd3048, 12'd1048, 1'b1, 1'b1, 1000, 2048, 0);
        run_window(12'd3048, 12'd1048, 1'b1, 1'b1, 1000, 2048, 0);
        drain();

        // Step 500 -> 700: dc tracks 500, 500, 501 -> demod 2448, 2448, 2446.
        do_reset("reset before step");
        run_window(12'd2548, 12'd1548, 1'b0, 1'b1, 500, 2048, 0);
        run_window(12'd2748, 12'd1348, 1'b0, 1'b1, 700, 2448, 0);
        run_window(12'd2748, 12'd1348, 1'b0, 1'b1, 700, 2448, 0);
        run_window(12'd2748, 12'd1348, 1'b0, 1'b1, 700, 2446, 0);
        drain();

        // Saturation: seed 0, then am_data=0 (rect 2048) clamps high; dc 0 -> 8 -> 15.
        do_reset("reset before sat");
        run_window(12'd2048, 12'd2048, 1'b0, 1'b1, 0, 2048, 0);
        run_window(12'd0, 12'd0, 1'b0, 1'b1, 2048, 4095, 1);
        run_window(12'd0, 12'd0, 1'b0, 1'b1, 2048, 4095, 1);
        run_window(12'd2048, 12'd2048, 1'b0, 1'b1, 0, 2018, 1);
        drain();
        check("sat_flag sticky", int'(sat_flag), 1);

        // Reset mid-window: partial accumulation must be discarded.
        for (int i = 0; i < DECIM / 2; i++) begin
            @(negedge clk);
            am_data  = 12'd0;
            in_valid = 1'b1;
        end
        do_reset("reset mid-window");
        run_window(12'd3048, 12'd1048, 1'b0, 1'b1, 1000, 2048, 0);
        drain();

        // Reset mid-pipeline: completed window's dump is lost, next window re-seeds.
        run_window(12'd0, 12'd0, 1'b0, 1'b0, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        do_reset("reset mid-pipeline");
        repeat (10) @(negedge clk);
        check("no output after lost dump", int'(out_valid), 0);
        run_window(12'd0, 12'd0, 1'b0, 1'b1, 2048, 2048, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
